// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: command codes, FSM state encoding and
// the default memory address widths.
package program_loader_pkg;

    localparam int INST_AW_DEF = 6;
    localparam int DATA_AW_DEF = 8;

    localparam logic [7:0] LDR_CMD_LOAD_INST = 8'h01;
    localparam logic [7:0] LDR_CMD_LOAD_DATA = 8'h02;
    localparam logic [7:0] LDR_CMD_RUN       = 8'h03;
    localparam logic [7:0] LDR_CMD_HALT      = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_CNT_HI  = 3'd3,
        ST_CNT_LO  = 3'd4,
        ST_PAYLOAD = 3'd5
    } ldr_state_t;

    function automatic logic is_load_cmd(input logic [7:0] cmd);
        return (cmd == LDR_CMD_LOAD_INST) || (cmd == LDR_CMD_LOAD_DATA);
    endfunction

endpackage

// File: rtl/ldr_word_assembler.sv
// Packs a big-endian byte stream into 16- or 32-bit words; o_word/o_word_valid are
// combinational on the final byte so the parent can register the write in the same edge.
module ldr_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_wide,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [1:0]  w_last_idx;

    assign w_last_idx   = i_wide ? 2'd3 : 2'd1;
    assign o_word_valid = i_byte_valid && (r_idx == w_last_idx);
    assign o_word       = i_wide ? {r_shift, i_byte} : {16'h0000, r_shift[7:0], i_byte};

    // Byte shift register and position within the current word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift <= 24'h000000;
            r_idx   <= 2'd0;
        end else if (i_clr) begin
            r_shift <= 24'h000000;
            r_idx   <= 2'd0;
        end else if (i_byte_valid) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_idx   <= (r_idx == w_last_idx) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_shift <= r_shift;
            r_idx   <= r_idx;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Host-side loader: decodes LOAD/RUN/HALT frames from a byte stream, writes instruction
// or data memory and owns the core's lock (run-enable).
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INST_AW = INST_AW_DEF,
    parameter int DATA_AW = DATA_AW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               inst_we,
    output logic [INST_AW-1:0] inst_waddr,
    output logic [31:0]        inst_wdata,
    output logic               data_we,
    output logic [DATA_AW-1:0] data_waddr,
    output logic [15:0]        data_wdata,
    output logic               lock,
    output logic               busy,
    output logic               err,
    output logic [15:0]        words_loaded
);

    ldr_state_t         r_state;
    ldr_state_t         w_state_nxt;
    logic               r_rx_ready;
    logic               r_is_inst;
    logic [15:0]        r_addr;
    logic [15:0]        r_cnt;
    logic [15:0]        r_k;
    logic               r_inst_we;
    logic [INST_AW-1:0] r_inst_waddr;
    logic [31:0]        r_inst_wdata;
    logic               r_data_we;
    logic [DATA_AW-1:0] r_data_waddr;
    logic [15:0]        r_data_wdata;
    logic               r_lock;
    logic               r_busy;
    logic               r_err;
    logic [15:0]        r_words;

    logic               w_accept;
    logic               w_word_valid;
    logic [31:0]        w_word;
    logic               w_last_word;

    assign w_accept    = rx_valid && r_rx_ready;
    assign w_last_word = (r_k == (r_cnt - 16'd1));

    ldr_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (r_state != ST_PAYLOAD),
        .i_wide       (r_is_inst),
        .i_byte_valid (w_accept && (r_state == ST_PAYLOAD)),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // Frame sequencing: header bytes, then payload until the last word is assembled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && is_load_cmd(rx_data)) w_state_nxt = ST_ADDR_HI;
                        else w_state_nxt = ST_IDLE;
            ST_ADDR_HI: if (w_accept) w_state_nxt = ST_ADDR_LO; else w_state_nxt = ST_ADDR_HI;
            ST_ADDR_LO: if (w_accept) w_state_nxt = ST_CNT_HI;  else w_state_nxt = ST_ADDR_LO;
            ST_CNT_HI:  if (w_accept) w_state_nxt = ST_CNT_LO;  else w_state_nxt = ST_CNT_HI;
            ST_CNT_LO: begin
                if (w_accept) begin
                    if ({r_cnt[15:8], rx_data} == 16'd0) w_state_nxt = ST_IDLE;
                    else w_state_nxt = ST_PAYLOAD;
                end else begin
                    w_state_nxt = ST_CNT_LO;
                end
            end
            ST_PAYLOAD: if (w_word_valid && w_last_word) w_state_nxt = ST_IDLE;
                        else w_state_nxt = ST_PAYLOAD;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // State, header capture, lock control and registered write ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rx_ready   <= 1'b0;
            r_is_inst    <= 1'b0;
            r_addr       <= 16'd0;
            r_cnt        <= 16'd0;
            r_k          <= 16'd0;
            r_inst_we    <= 1'b0;
            r_inst_waddr <= '0;
            r_inst_wdata <= 32'd0;
            r_data_we    <= 1'b0;
            r_data_waddr <= '0;
            r_data_wdata <= 16'd0;
            r_lock       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_words      <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_rx_ready <= 1'b1;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_inst_we  <= 1'b0;
            r_data_we  <= 1'b0;
            r_err      <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        case (rx_data)
                            LDR_CMD_LOAD_INST: begin
                                r_is_inst <= 1'b1;
                                r_lock    <= 1'b0;
                                r_words   <= 16'd0;
                            end
                            LDR_CMD_LOAD_DATA: begin
                                r_is_inst <= 1'b0;
                                r_lock    <= 1'b0;
                                r_words   <= 16'd0;
                            end
                            LDR_CMD_RUN:  r_lock <= 1'b1;
                            LDR_CMD_HALT: r_lock <= 1'b0;
                            default:      r_err  <= 1'b1;
                        endcase
                    end
                    ST_ADDR_HI: r_addr[15:8] <= rx_data;
                    ST_ADDR_LO: r_addr[7:0]  <= rx_data;
                    ST_CNT_HI:  r_cnt[15:8]  <= rx_data;
                    ST_CNT_LO: begin
                        r_cnt[7:0] <= rx_data;
                        r_k        <= 16'd0;
                    end
                    ST_PAYLOAD: begin
                        // Address wraps modulo memory size by truncating the 16-bit sum.
                        if (w_word_valid) begin
                            if (r_is_inst) begin
                                r_inst_we    <= 1'b1;
                                r_inst_waddr <= INST_AW'(r_addr + r_k);
                                r_inst_wdata <= w_word;
                            end else begin
                                r_data_we    <= 1'b1;
                                r_data_waddr <= DATA_AW'(r_addr + r_k);
                                r_data_wdata <= w_word[15:0];
                            end
                            r_k     <= r_k + 16'd1;
                            r_words <= r_k + 16'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready     = r_rx_ready;
    assign inst_we      = r_inst_we;
    assign inst_waddr   = r_inst_waddr;
    assign inst_wdata   = r_inst_wdata;
    assign data_we      = r_data_we;
    assign data_waddr   = r_data_waddr;
    assign data_wdata   = r_data_wdata;
    assign lock         = r_lock;
    assign busy         = r_busy;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule
